// File: rtl/mac_ctrl_avmm_master_if.sv
// Command/response and Avalon-MM signal bundle for mac_ctrl_avmm_master.
// The master modport is the engine's view. The slave modport is the view
// of the sequencer and MAC control port that face it.
interface mac_ctrl_avmm_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, readdata, waitrequest,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, address, write, read, writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, readdata, waitrequest,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, address, write, read, writedata
  );
endinterface

// File: rtl/mac_ctrl_avmm_master.sv
// Single-outstanding Avalon-MM master for one MAC control port.
// It accepts one register command, runs the bus transfer while honouring
// waitrequest, and returns a one-cycle response strobe.
// Optional feature: define MAC_CTRL_TIMEOUT_EN to build the waitrequest
// timeout abort path and the timeout_cnt counter.
module mac_ctrl_avmm_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  mac_ctrl_avmm_master_if.master        bus,
  output logic [15:0]                   timeout_cnt
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state_q, state_d;
  logic   done;
  logic   abort;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef MAC_CTRL_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Abort only once the counter has already reached the limit and the slave still stalls.
  assign timeout_hit = bus.waitrequest && (wait_cnt >= 16'(TIMEOUT_CYCLES));

  // Wait-state counter: cleared on accept, counts stalled BUS cycles, never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_q == IDLE && bus.cmd_valid) begin
      wait_cnt <= '0;
    end else if (state_q == BUS && bus.waitrequest && wait_cnt != '1) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Count aborted transfers and hold the count at 0xFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (abort && timeout_cnt != '1) begin
      timeout_cnt <= timeout_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_cnt = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A completion takes priority over a timeout on the same edge.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = BUS;
        end
      end
      BUS: begin
        if (!bus.waitrequest) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs. cmd_ready and rsp_valid are decoded from the next state,
  // so they line up with the state register without any input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.address   <= '0;
      bus.write     <= 1'b0;
      bus.read      <= 1'b0;
      bus.writedata <= '0;
    end else begin
      bus.cmd_ready <= (state_d == IDLE);
      bus.rsp_valid <= (state_d == RESP);
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.address   <= bus.cmd_addr;
            bus.writedata <= bus.cmd_wdata;
            bus.write     <= bus.cmd_write;
            bus.read      <= !bus.cmd_write;
          end
        end
        BUS: begin
          if (done || abort) begin
            bus.write     <= 1'b0;
            bus.read      <= 1'b0;
            bus.rsp_err   <= abort;
            bus.rsp_rdata <= (done && bus.read) ? bus.readdata : '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
